// File: rtl/chacha_unround.sv
// Iterative inverse ChaCha block: undoes ROUNDS forward rounds, one inverse quarterround per cycle.
// Word k of the 512-bit state sits in bits [511-32k -: 32]; in the packed array that is slot ~k.

module chacha_inv_qr (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [31:0] d,
   output logic [31:0] a0,
   output logic [31:0] b0,
   output logic [31:0] c0,
   output logic [31:0] d0
);
   logic [31:0] a1, b1, c1, d1;

   // Forward QR steps replayed backwards: un-rotate, un-xor, un-add.
   always_comb begin
      b1 = {b[6:0], b[31:7]} ^ c;
      c1 = c - d;
      d1 = {d[7:0], d[31:8]} ^ a;
      a1 = a - b1;
      b0 = {b1[11:0], b1[31:12]} ^ c1;
      c0 = c1 - d1;
      d0 = {d1[15:0], d1[31:16]} ^ a1;
      a0 = a1 - b0;
   end
endmodule

module chacha_unround #(
   parameter int ROUNDS = 20
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         init,
   input  logic [511:0] state_in,
   output logic         ready,
   output logic [511:0] state_out,
   output logic         state_out_valid
);
   generate
      if (ROUNDS < 2 || ROUNDS > 20 || (ROUNDS % 2) != 0) begin : g_bad_rounds
         $error("chacha_unround: ROUNDS must be even and within 2..20");
      end
   endgenerate

   localparam logic [3:0] DR_LAST = 4'(ROUNDS / 2 - 1);

   typedef enum logic [1:0] {IDLE, DIAG, COL} st_t;

   st_t                st;
   logic [1:0]         qr_ctr;
   logic [3:0]         dr_ctr;
   logic [15:0][31:0]  w;
   logic [15:0][31:0]  next_w;
   logic [3:0]         ia, ib, ic, id;
   logic [31:0]        a0, b0, c0, d0;

   // Word indices of the current group; diagonals wrap within each row.
   always_comb begin
      ia = {2'b00, qr_ctr};
      if (st == DIAG) begin
         ib = {2'b01, qr_ctr + 2'd1};
         ic = {2'b10, qr_ctr + 2'd2};
         id = {2'b11, qr_ctr + 2'd3};
      end else begin
         ib = {2'b01, qr_ctr};
         ic = {2'b10, qr_ctr};
         id = {2'b11, qr_ctr};
      end
   end

   chacha_inv_qr u_iqr (
      .a  (w[~ia]),
      .b  (w[~ib]),
      .c  (w[~ic]),
      .d  (w[~id]),
      .a0 (a0),
      .b0 (b0),
      .c0 (c0),
      .d0 (d0)
   );

   always_comb begin
      next_w       = w;
      next_w[~ia]  = a0;
      next_w[~ib]  = b0;
      next_w[~ic]  = c0;
      next_w[~id]  = d0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st              <= IDLE;
         qr_ctr          <= '0;
         dr_ctr          <= '0;
         w               <= '0;
         ready           <= 1'b1;
         state_out       <= '0;
         state_out_valid <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               if (init) begin
                  w               <= state_in;
                  qr_ctr          <= '0;
                  dr_ctr          <= '0;
                  ready           <= 1'b0;
                  state_out_valid <= 1'b0;
                  st              <= DIAG;
               end
            end
            DIAG: begin
               w      <= next_w;
               qr_ctr <= qr_ctr + 2'd1;
               if (qr_ctr == 2'd3) st <= COL;
            end
            COL: begin
               w      <= next_w;
               qr_ctr <= qr_ctr + 2'd1;
               if (qr_ctr == 2'd3) begin
                  if (dr_ctr == DR_LAST) begin
                     state_out       <= next_w;
                     state_out_valid <= 1'b1;
                     ready           <= 1'b1;
                     st              <= IDLE;
                  end else begin
                     dr_ctr <= dr_ctr + 4'd1;
                     st     <= DIAG;
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule
